// File: rtl/bcd_clock_counter_if.sv
// bcd_clock_counter_if: request/response bundle between the time counter and its neighbours
interface bcd_clock_counter_if #(parameter int W = 16);
    logic         advance;
    logic         loadTime;
    logic [W-1:0] setData;
    logic         incHour;
    logic         incMin;
    logic         mode12;
    logic [W-1:0] timeData;
    logic [W-1:0] dispData;
    logic         pm;
    logic         dayTick;
    logic         loadErr;
    modport master (
        output advance, loadTime, setData, incHour, incMin, mode12,
        input  timeData, dispData, pm, dayTick, loadErr
    );
    modport slave (
        input  advance, loadTime, setData, incHour, incMin, mode12,
        output timeData, dispData, pm, dayTick, loadErr
    );
endinterface

// File: rtl/bcd_clock_counter.sv
// bcd_clock_counter: packed-BCD time-of-day counter with load, button increments and 12/24 h display
module bcd_clock_counter #(
    parameter bit                                 SECONDS_EN = 0,
    parameter logic [(SECONDS_EN ? 24 : 16)-1:0] RESET_TIME = '0
) (
    input logic                clk,
    input logic                rst_n,
    bcd_clock_counter_if.slave bus
);
    localparam int W = SECONDS_EN ? 24 : 16;
    localparam int H = W - 8;
    localparam int M = W - 16;

    function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
        return (v == top) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic ok60(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic ok24(input logic [7:0] v);
        return ((v[7:4] < 4'd2) && (v[3:0] <= 4'd9)) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
    endfunction

    // 13..23 map to 01..11 digit by digit; 20/21 borrow across the tens digit
    function automatic logic [7:0] hr12(input logic [7:0] h);
        return (h == 8'h00) ? 8'h12 :
               (h <= 8'h12) ? h :
               (h[7:4] == 4'd1) ? {4'd0, h[3:0] - 4'd2} :
               (h[3:0] < 4'd2) ? {4'd0, h[3:0] + 4'd8} : {4'd1, h[3:0] - 4'd2};
    endfunction

    logic [W-1:0] time_q, disp_q, nxt, disp_n;
    logic         pm_q, day_q, err_q, pm_n, day_n, err_n;
    logic         sec_c, min_c, load_ok;

    // seconds field only exists when enabled; otherwise every advance is a minute carry
    assign sec_c   = SECONDS_EN ? (time_q[7:0] == 8'h59) : 1'b1;
    assign min_c   = sec_c && (time_q[M +: 8] == 8'h59);
    assign load_ok = ok24(bus.setData[H +: 8]) && ok60(bus.setData[M +: 8]) &&
                     (!SECONDS_EN || ok60(bus.setData[7:0]));

    // next time by priority: load, then button increments, then tick
    always_comb begin
        nxt   = time_q;
        day_n = 1'b0;
        err_n = 1'b0;
        if (bus.loadTime) begin
            nxt   = load_ok ? bus.setData : time_q;
            err_n = !load_ok;
        end else if (bus.incHour || bus.incMin) begin
            if (bus.incHour) nxt[H +: 8] = inc_bcd(time_q[H +: 8], 8'h23);
            if (bus.incMin) nxt[M +: 8] = inc_bcd(time_q[M +: 8], 8'h59);
            if (bus.incMin && SECONDS_EN) nxt[7:0] = 8'h00;
        end else if (bus.advance) begin
            if (SECONDS_EN) nxt[7:0] = inc_bcd(time_q[7:0], 8'h59);
            nxt[M +: 8] = sec_c ? inc_bcd(time_q[M +: 8], 8'h59) : time_q[M +: 8];
            nxt[H +: 8] = min_c ? inc_bcd(time_q[H +: 8], 8'h23) : time_q[H +: 8];
            day_n       = min_c && (time_q[H +: 8] == 8'h23);
        end
    end

    // display word follows the next-state time so it lines up with timeData
    always_comb begin
        disp_n = nxt;
        if (bus.mode12) disp_n[H +: 8] = hr12(nxt[H +: 8]);
        pm_n = bus.mode12 && (nxt[H +: 8] >= 8'h12);
    end

    // all outputs registered; reset shows RESET_TIME in 24 h form
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= RESET_TIME;
            disp_q <= RESET_TIME;
            pm_q   <= 1'b0;
            day_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            time_q <= nxt;
            disp_q <= disp_n;
            pm_q   <= pm_n;
            day_q  <= day_n;
            err_q  <= err_n;
        end
    end

    assign bus.timeData = time_q;
    assign bus.dispData = disp_q;
    assign bus.pm       = pm_q;
    assign bus.dayTick  = day_q;
    assign bus.loadErr  = err_q;
endmodule

// File: tb/tb_bcd_clock_counter.sv
// tb_bcd_clock_counter: vector table plus scoreboard for the hh:mm and hh:mm:ss counters
module tb_bcd_clock_counter;
    logic clk;
    logic rst_n;

    bcd_clock_counter_if #(.W(16)) if16();
    bcd_clock_counter_if #(.W(24)) if24();

    bcd_clock_counter #(.SECONDS_EN(0), .RESET_TIME(16'h0000)) d16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    bcd_clock_counter #(.SECONDS_EN(1), .RESET_TIME(24'h000000)) d24 (.clk(clk), .rst_n(rst_n), .bus(if24));

    typedef struct {
        bit          s24;
        logic        adv, ld, ih, im, m12;
        logic [23:0] sd;
        logic [23:0] et, ed;
        logic        ep, eday, eerr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(bit s, logic adv, logic ld, logic ih, logic im, logic m12,
                                logic [23:0] sd, logic [23:0] et, logic [23:0] ed,
                                logic ep, logic eday, logic eerr);
        vec_t v;
        v.s24 = s; v.adv = adv; v.ld = ld; v.ih = ih; v.im = im; v.m12 = m12;
        v.sd = sd; v.et = et; v.ed = ed; v.ep = ep; v.eday = eday; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(string nm, logic [23:0] act, logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        if16.advance = 0; if16.loadTime = 0; if16.incHour = 0; if16.incMin = 0; if16.mode12 = 0; if16.setData = '0;
        if24.advance = 0; if24.loadTime = 0; if24.incHour = 0; if24.incMin = 0; if24.mode12 = 0; if24.setData = '0;
        if (v.s24) begin
            if24.advance = v.adv; if24.loadTime = v.ld; if24.incHour = v.ih; if24.incMin = v.im;
            if24.mode12 = v.m12; if24.setData = v.sd;
        end else begin
            if16.advance = v.adv; if16.loadTime = v.ld; if16.incHour = v.ih; if16.incMin = v.im;
            if16.mode12 = v.m12; if16.setData = v.sd[15:0];
        end
        sb.push_back(v);
    endtask

    task automatic compare(string tag);
        vec_t e;
        logic [23:0] t, d;
        logic p, dy, er;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: scoreboard empty, got output with nothing expected", tag);
            return;
        end
        e  = sb.pop_front();
        t  = e.s24 ? if24.timeData : {8'h00, if16.timeData};
        d  = e.s24 ? if24.dispData : {8'h00, if16.dispData};
        p  = e.s24 ? if24.pm : if16.pm;
        dy = e.s24 ? if24.dayTick : if16.dayTick;
        er = e.s24 ? if24.loadErr : if16.loadErr;
        check({tag, " timeData"}, t, e.et);
        check({tag, " dispData"}, d, e.ed);
        check({tag, " pm"}, {23'd0, p}, {23'd0, e.ep});
        check({tag, " dayTick"}, {23'd0, dy}, {23'd0, e.eday});
        check({tag, " loadErr"}, {23'd0, er}, {23'd0, e.eerr});
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic check_reset(string tag);
        check({tag, " t16"}, {8'h00, if16.timeData}, 24'h0);
        check({tag, " d16"}, {8'h00, if16.dispData}, 24'h0);
        check({tag, " flags16"}, {21'd0, if16.pm, if16.dayTick, if16.loadErr}, 24'h0);
        check({tag, " t24"}, if24.timeData, 24'h0);
        check({tag, " d24"}, if24.dispData, 24'h0);
        check({tag, " flags24"}, {21'd0, if24.pm, if24.dayTick, if24.loadErr}, 24'h0);
    endtask

    initial begin
        // hh:mm
        tbl.push_back(mk(0, 0,1,0,0,0, 'h0107, 'h0107, 'h0107, 0,0,0));
        tbl.push_back(mk(0, 1,0,0,0,0, 'h0,    'h0108, 'h0108, 0,0,0));
        tbl.push_back(mk(0, 1,0,0,0,0, 'h0,    'h0109, 'h0109, 0,0,0));
        tbl.push_back(mk(0, 1,0,0,0,0, 'h0,    'h0110, 'h0110, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h2359, 'h2359, 'h1159, 1,0,0));
        tbl.push_back(mk(0, 1,0,0,0,1, 'h0,    'h0000, 'h1200, 0,1,0));
        tbl.push_back(mk(0, 0,0,0,0,1, 'h0,    'h0000, 'h1200, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,0, 'h2460, 'h0000, 'h0000, 0,0,1));
        tbl.push_back(mk(0, 0,1,0,0,0, 'h1A00, 'h0000, 'h0000, 0,0,1));
        tbl.push_back(mk(0, 0,0,0,0,0, 'h0,    'h0000, 'h0000, 0,0,0));
        tbl.push_back(mk(0, 1,1,0,0,0, 'h1234, 'h1234, 'h1234, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,0, 'h0959, 'h0959, 'h0959, 0,0,0));
        tbl.push_back(mk(0, 1,0,0,0,0, 'h0,    'h1000, 'h1000, 0,0,0));
        tbl.push_back(mk(0, 0,1,1,0,0, 'h2359, 'h2359, 'h2359, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,0,0, 'h0,    'h0059, 'h0059, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,1,0, 'h0,    'h0000, 'h0000, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,1,0, 'h0,    'h0101, 'h0101, 0,0,0));
        tbl.push_back(mk(0, 1,0,1,0,0, 'h0,    'h0201, 'h0201, 0,0,0));
        tbl.push_back(mk(0, 1,0,0,1,0, 'h0,    'h0202, 'h0202, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h0000, 'h0000, 'h1200, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h0130, 'h0130, 'h0130, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h1145, 'h1145, 'h1145, 0,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h1200, 'h1200, 'h1200, 1,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h1305, 'h1305, 'h0105, 1,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h2000, 'h2000, 'h0800, 1,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h2215, 'h2215, 'h1015, 1,0,0));
        tbl.push_back(mk(0, 0,1,0,0,1, 'h2359, 'h2359, 'h1159, 1,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0, 'h0,    'h2359, 'h2359, 0,0,0));
        // hh:mm:ss
        tbl.push_back(mk(1, 0,1,0,0,0, 'h095959, 'h095959, 'h095959, 0,0,0));
        tbl.push_back(mk(1, 1,0,0,0,0, 'h0,      'h100000, 'h100000, 0,0,0));
        tbl.push_back(mk(1, 0,1,0,0,0, 'h235959, 'h235959, 'h235959, 0,0,0));
        tbl.push_back(mk(1, 1,0,0,0,0, 'h0,      'h000000, 'h000000, 0,1,0));
        tbl.push_back(mk(1, 0,0,0,0,0, 'h0,      'h000000, 'h000000, 0,0,0));
        tbl.push_back(mk(1, 0,1,0,0,0, 'h105930, 'h105930, 'h105930, 0,0,0));
        tbl.push_back(mk(1, 0,0,0,1,0, 'h0,      'h100000, 'h100000, 0,0,0));
        tbl.push_back(mk(1, 0,1,0,0,0, 'h105960, 'h100000, 'h100000, 0,0,1));
        tbl.push_back(mk(1, 1,0,0,0,0, 'h0,      'h100001, 'h100001, 0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,1, 'h0,      'h100001, 'h100001, 0,0,0));
        tbl.push_back(mk(1, 0,1,0,0,1, 'h130000, 'h130000, 'h010000, 1,0,0));
        tbl.push_back(mk(1, 0,1,0,0,0, 'h006100, 'h130000, 'h130000, 0,0,1));
        tbl.push_back(mk(1, 0,1,0,0,0, 'h00000A, 'h130000, 'h130000, 0,0,1));

        rst_n = 1'b0;
        drive(mk(0, 0,0,0,0,0, 0, 0, 0, 0,0,0));
        void'(sb.pop_front());
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // async reset mid-sweep, right after a dayTick pulse
        apply(mk(0, 0,1,0,0,1, 'h1305, 'h1305, 'h0105, 1,0,0), "pre_rst_load");
        apply(mk(0, 0,1,0,0,1, 'h2359, 'h2359, 'h1159, 1,0,0), "pre_rst_2359");
        @(negedge clk);
        drive(mk(0, 1,0,0,0,1, 0, 'h0000, 'h1200, 0,1,0));
        @(posedge clk);
        #2;
        compare("pre_rst_wrap");
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 0,1,0,0,0, 'h0107, 'h0107, 'h0107, 0,0,0), "post_rst_load");
        apply(mk(1, 1,0,0,0,0, 'h0,    'h000001, 'h000001, 0,0,0), "post_rst_adv24");

        check("scoreboard_drained", 24'(sb.size()), 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
